// File: rtl/lzc_arbiter.sv
// lzc_arbiter: round-robin scheduler sharing one leading-zero-count engine.
// Optional LZC_ARB_STATS_EN adds frame and timeout counters.
module lzc_arbiter #(
   parameter int WIDTH   = 8,
   parameter int WORD    = 4,
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 64,
   localparam int ZW  = $clog2(WIDTH*WORD) + 1,
   localparam int IDW = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [NREQ-1:0]   req_valid,
   input  logic [NREQ*WIDTH-1:0] req_data,
   input  logic [NREQ-1:0]   req_mode,
   output logic [NREQ-1:0]   req_ready,
   output logic [WIDTH-1:0]  lzc_data,
   output logic              lzc_ivalid,
   output logic              lzc_mode,
   input  logic [ZW-1:0]     lzc_zeros,
   input  logic              lzc_ovalid,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ZW-1:0]     res_zeros,
   output logic [IDW-1:0]    res_id,
   output logic              res_err,
   output logic              busy
`ifdef LZC_ARB_STATS_EN
   ,
   output logic [15:0]       stat_frames,
   output logic [15:0]       stat_timeouts
`endif
);

   localparam int BW = (WORD > 1) ? $clog2(WORD) : 1;
   localparam int TW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_FEED,
      S_WAIT,
      S_RESP
   } state_t;

   state_t           r_state;
   state_t           w_next;
   logic [IDW-1:0]   r_grant;
   logic [IDW-1:0]   r_last;
   logic             r_mode;
   logic [BW-1:0]    r_beat;
   logic [TW-1:0]    r_tmo;
   logic [WIDTH-1:0] r_data;
   logic             r_ivalid;
   logic [ZW-1:0]    r_zeros;
   logic             r_err;

   logic             w_found;
   logic [IDW-1:0]   w_pick;
   logic             w_accept;
   logic             w_last_beat;
   logic             w_tmo_hit;
   logic [WIDTH-1:0] w_beat;

   // first requesting index above the last served one, wrapping
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      for (int k = 1; k <= NREQ; k++) begin
         if (!w_found &&
             req_valid[IDW'((int'(r_last) + k) % NREQ)]) begin
            w_found = 1'b1;
            w_pick  = IDW'((int'(r_last) + k) % NREQ);
         end
      end
   end

   assign w_accept    = (r_state == S_FEED) && req_valid[r_grant];
   assign w_last_beat = w_accept && (r_beat == BW'(WORD - 1));
   assign w_tmo_hit   = (r_tmo == TW'(TIMEOUT - 1));
   assign w_beat      = req_data[int'(r_grant)*WIDTH +: WIDTH];

   // only the granted requester sees ready, and only while feeding
   always_comb begin
      req_ready = '0;
      if (r_state == S_FEED) req_ready[r_grant] = 1'b1;
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // next-state decode; ovalid wins over an expiring timeout
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: if (w_found) w_next = S_FEED;
         S_FEED: if (w_last_beat) w_next = S_WAIT;
         S_WAIT: if (lzc_ovalid || w_tmo_hit) w_next = S_RESP;
         S_RESP: if (res_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // grant, beat streaming, wait timer and result capture
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant  <= '0;
         r_last   <= IDW'(NREQ - 1);
         r_mode   <= 1'b0;
         r_beat   <= '0;
         r_tmo    <= '0;
         r_data   <= '0;
         r_ivalid <= 1'b0;
         r_zeros  <= '0;
         r_err    <= 1'b0;
      end else begin
         r_ivalid <= 1'b0;
         r_tmo    <= (r_state == S_WAIT) ? r_tmo + TW'(1) : '0;
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_grant <= w_pick;
                  r_mode  <= req_mode[w_pick];
               end
            end
            S_FEED: begin
               if (w_accept) begin
                  r_data   <= w_beat;
                  r_ivalid <= 1'b1;
                  r_beat   <= w_last_beat ? '0 : r_beat + BW'(1);
               end
            end
            S_WAIT: begin
               if (lzc_ovalid) begin
                  r_zeros <= lzc_zeros;
                  r_err   <= 1'b0;
               end else if (w_tmo_hit) begin
                  r_zeros <= '0;
                  r_err   <= 1'b1;
               end
            end
            S_RESP: begin
               if (res_ready) r_last <= r_grant;
            end
            default: ;
         endcase
      end
   end

   assign lzc_data   = r_data;
   assign lzc_ivalid = r_ivalid;
   assign lzc_mode   = r_mode;
   assign res_valid  = (r_state == S_RESP);
   assign res_id     = res_valid ? r_grant : '0;
   assign res_zeros  = r_zeros;
   assign res_err    = r_err;
   assign busy       = (r_state != S_IDLE);

`ifdef LZC_ARB_STATS_EN
   logic [15:0] r_frames;
   logic [15:0] r_timeouts;

   // saturating counters of completed result handshakes
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_frames   <= '0;
         r_timeouts <= '0;
      end else if (res_valid && res_ready) begin
         if (r_frames != 16'hFFFF) r_frames <= r_frames + 16'd1;
         if (r_err && r_timeouts != 16'hFFFF)
            r_timeouts <= r_timeouts + 16'd1;
      end
   end

   assign stat_frames   = r_frames;
   assign stat_timeouts = r_timeouts;
`endif

endmodule

// File: doc/lzc_arbiter.md
Name: lzc_arbiter

Overview:
- Round-robin scheduler that shares one leading-zero-count engine among NREQ requesters.
- Each requester submits a frame of WORD beats, WIDTH bits per beat, MSB beat first. The arbiter streams the frame into the engine, waits for the count and returns it tagged with the requester ID.
- Sits between requester-side beat interfaces and the single lzc engine instance; owns all engine sequencing and mode selection.

Parameters:
- WIDTH, 8, bits per beat.
- WORD, 4, beats per frame.
- NREQ, 4, number of requesters (2..16).
- TIMEOUT, 64, max cycles in WAIT before the frame is aborted (>=2).
- Derived, not overridable: ZW = $clog2(WIDTH*WORD)+1; IDW = max(1,$clog2(NREQ)).

Ports:
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  NREQ  per-requester beat valid
- req_data  in  NREQ*WIDTH  requester i beat at [i*WIDTH +: WIDTH]
- req_mode  in  NREQ  per-requester mode: 0 normal, 1 turbo
- req_ready  out  NREQ  beat accept, at most one bit set
- lzc_data  out  WIDTH  beat to engine
- lzc_ivalid  out  1  beat valid to engine
- lzc_mode  out  1  engine mode for the current frame
- lzc_zeros  in  ZW  engine result
- lzc_ovalid  in  1  engine result valid, 1-cycle pulse
- res_valid  out  1  result available
- res_ready  in  1  result consumer ready
- res_zeros  out  ZW  leading-zero count
- res_id  out  IDW  requester that owns the result
- res_err  out  1  1 = timeout abort
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; beat counter 0; timeout counter 0.
  - last_grant = NREQ-1, so the first search starts at requester 0.
  - Reset asserted mid-frame aborts the frame; no result is produced.
- Beat handshake: a beat is accepted when req_valid[i] && req_ready[i].
- States: IDLE, FEED, WAIT, RESP. Registered state; req_ready is combinational from state and grant.
- IDLE:
  - If any req_valid is set, grant the first set bit searching upward from last_grant+1 (mod NREQ).
  - Register grant, and register lzc_mode <= req_mode[grant].
  - Next state FEED. No beat is accepted in the grant cycle.
- FEED:
  - req_ready[grant] = 1; all other req_ready bits 0.
  - Each accepted beat: lzc_data <= beat and lzc_ivalid <= 1 on the next edge; beat counter increments.
  - Any cycle without an accepted beat gives lzc_ivalid <= 0; counter holds. Requester stalls are legal.
  - Exactly WORD ivalid beats are issued per frame.
  - When beat WORD-1 is accepted: counter clears, next state WAIT.
- WAIT:
  - Timeout counter starts at 0 on entry and increments each cycle.
  - lzc_ovalid = 1: res_zeros <= lzc_zeros, res_err <= 0, next state RESP.
  - Counter reaches TIMEOUT-1 with no ovalid: res_zeros <= 0, res_err <= 1, next state RESP.
  - ovalid in the expiry cycle takes priority over the timeout.
- RESP:
  - res_valid = 1; res_id = grant.
  - res_zeros, res_err and res_id are held stable until res_ready.
  - On res_valid && res_ready: last_grant <= grant, next state IDLE. The earliest next grant is the following cycle.
- lzc_ovalid outside WAIT is ignored.
- lzc_mode is constant from the grant cycle through the end of RESP.
- Width rules:
  - res_zeros is passed through unchanged; the legal range is 0..WIDTH*WORD.
  - The timeout counter is $clog2(TIMEOUT) bits.
- A req_valid deassert by a non-granted requester has no effect on the current frame.

Optional Feature:
- Macro: LZC_ARB_STATS_EN.
- Defined: adds outputs stat_frames[15:0] and stat_timeouts[15:0].
  - stat_frames counts completed RESP handshakes.
  - stat_timeouts counts handshakes with res_err = 1.
  - Both saturate at 16'hFFFF and reset to 0.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Basic frame: req 0 only, mode 0, beats 00,00,1F,FF; engine model returns 19 -> res_valid, res_id=0, res_zeros=19, res_err=0, lzc_mode=0, exactly 4 lzc_ivalid pulses.
- Round-robin fairness: all 4 req_valid held high, res_ready=1 -> grant order 0,1,2,3,0, each with its own data and mode reflected on lzc_mode.
- Requester stall: req 2 drops req_valid for 3 cycles after beat 1 -> lzc_ivalid low for those 3 cycles, 4 ivalid beats total, correct count returned.
- Timeout: engine never pulses ovalid, TIMEOUT=16 -> RESP entered 16 cycles after WAIT entry, res_err=1, res_zeros=0; stat_timeouts=1 when LZC_ARB_STATS_EN is defined.
- Backpressure: res_ready low for 5 cycles -> res_valid held, outputs stable, req_ready all 0, no new grant until the handshake completes.
- Reset mid-FEED: rst_n low after 2 beats -> all outputs 0 immediately; after release, req 1 and req 3 valid -> req 1 granted first.
